// File: rtl/lane_copier_pipe.sv
// Lane-masked copy/invert/broadcast unit with an output register plus one skid register.
// Define LANE_COPIER_PIPE_STATS_EN to add a saturating completed-transfer counter (xfer_count).
`timescale 1ns/1ps
module lane_copier_pipe #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                op,
  input  logic [LANES-1:0]          lane_mask,
  input  logic [LANES*LANE_W-1:0]   a,
  input  logic [LANES*LANE_W-1:0]   b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   y1,
  output logic [LANES*LANE_W-1:0]   y2
`ifdef LANE_COPIER_PIPE_STATS_EN
  ,
  output logic [15:0]               xfer_count
`endif
);

  localparam int W = LANES * LANE_W;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t         state_reg, state_next;
  logic           in_ready_reg;
  logic [W-1:0]   y1_reg, y1_next, y2_reg, y2_next;
  logic [W-1:0]   skid_y1_reg, skid_y1_next, skid_y2_reg, skid_y2_next;
  logic [W-1:0]   calc_y1, calc_y2;
  logic           acc, cmp;

  // y1 uses only the enabled lanes, y2 only the disabled ones
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LANE_W-1:0] a_lane, res;
      assign a_lane = a[gi*LANE_W +: LANE_W];
      always_comb begin
        case (op)
          2'b00:   res = '0;
          2'b01:   res = a_lane;
          2'b10:   res = ~a_lane;
          default: res = a[LANE_W-1:0];
        endcase
      end
      assign calc_y1[gi*LANE_W +: LANE_W] = lane_mask[gi] ? res : '0;
      assign calc_y2[gi*LANE_W +: LANE_W] = lane_mask[gi] ? '0 : b[gi*LANE_W +: LANE_W];
    end
  endgenerate

  assign acc       = in_valid & in_ready_reg;
  assign out_valid = (state_reg != EMPTY);
  assign cmp       = out_valid & out_ready;
  assign in_ready  = in_ready_reg;
  assign y1        = y1_reg;
  assign y2        = y2_reg;

  always_comb begin
    state_next   = state_reg;
    y1_next      = y1_reg;
    y2_next      = y2_reg;
    skid_y1_next = skid_y1_reg;
    skid_y2_next = skid_y2_reg;
    case (state_reg)
      EMPTY: begin
        if (acc) begin
          state_next = ONE;
          y1_next    = calc_y1;
          y2_next    = calc_y2;
        end
      end
      ONE: begin
        if (acc && cmp) begin
          y1_next = calc_y1;
          y2_next = calc_y2;
        end else if (acc) begin
          state_next   = TWO;
          skid_y1_next = calc_y1;
          skid_y2_next = calc_y2;
        end else if (cmp) begin
          state_next = EMPTY;
          y1_next    = '0;
          y2_next    = '0;
        end
      end
      TWO: begin
        // in_ready is low here, so only a completion can move the pipe
        if (cmp) begin
          state_next   = ONE;
          y1_next      = skid_y1_reg;
          y2_next      = skid_y2_reg;
          skid_y1_next = '0;
          skid_y2_next = '0;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      in_ready_reg <= 1'b0;
      y1_reg       <= '0;
      y2_reg       <= '0;
      skid_y1_reg  <= '0;
      skid_y2_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != TWO);
      y1_reg       <= y1_next;
      y2_reg       <= y2_next;
      skid_y1_reg  <= skid_y1_next;
      skid_y2_reg  <= skid_y2_next;
    end
  end

`ifdef LANE_COPIER_PIPE_STATS_EN
  logic [15:0] xfer_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count_reg <= '0;
    end else if (cmp && (xfer_count_reg != 16'hFFFF)) begin
      xfer_count_reg <= xfer_count_reg + 16'd1;
    end
  end

  assign xfer_count = xfer_count_reg;
`endif

endmodule
